// File: rtl/rr_arbiter_4req.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4req
//
// Purpose:
//   Four-requester round-robin arbiter for a shared resource. A rotating
//   priority search picks the first requester at or after the slot following
//   the last owner (wrapping 3->0). The owner keeps the grant until it drops
//   its request. Grants are registered so they can drive the resource select
//   directly and never glitch.
//
// Optional feature (compile-time macro HOLD_TIMEOUT_EN):
//   When defined, an owner is limited to MAX_HOLD consecutive grant cycles.
//   On timeout, the owner is masked and another requester is picked. If no
//   other requester is waiting, the owner is re-granted with a fresh count.
//   When undefined, the hold counter does not exist and MAX_HOLD/CNT_W are
//   only range-checked.
//
// Parameters:
//   MAX_HOLD  : max consecutive grant cycles per ownership (>= 2)
//   CNT_W     : hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req[3:0]  : request lines, req[i] high = requester i wants the resource
//   gnt[3:0]  : registered one-hot grant, all-zero when idle
//   gnt_id    : registered binary index of the owner, 2'b00 when idle
//   gnt_valid : registered, equals |gnt
// -----------------------------------------------------------------------------
module rr_arbiter_4req #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  // Reject configurations where the hold counter cannot reach MAX_HOLD-1.
  if ((MAX_HOLD < 2) || ((2 ** CNT_W) < MAX_HOLD)) begin : g_bad_cfg
    $error("rr_arbiter_4req: MAX_HOLD must be >= 2 and fit in CNT_W bits");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_gnt_id, w_gnt_id_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;

  logic       w_do_grant;
  logic [3:0] w_mask;
  logic [1:0] w_win;
  logic       w_owner_req;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [3:0]       w_others;
`endif

  // Rotating priority search: scan ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // Callers only use the result when mask is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

`ifdef HOLD_TIMEOUT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  assign w_owner_req = req[r_gnt_id];
  assign w_win       = rr_pick(w_mask, r_ptr);

`ifdef HOLD_TIMEOUT_EN
  assign w_others = req & ~onehot4(r_gnt_id);
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_ptr_nxt       = r_ptr;
    w_do_grant      = 1'b0;
    w_mask          = req;
`ifdef HOLD_TIMEOUT_EN
    w_hold_cnt_nxt  = r_hold_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (|req) w_do_grant = 1'b1;
      end
      ST_GRANT: begin
        if (w_owner_req) begin
`ifdef HOLD_TIMEOUT_EN
          if (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            if (|w_others) begin
              w_mask     = w_others;
              w_do_grant = 1'b1;
            end else begin
              // Nobody else waiting: owner keeps the resource, fresh budget.
              w_hold_cnt_nxt = '0;
            end
          end else begin
            w_hold_cnt_nxt = sat_inc(r_hold_cnt);
          end
`endif
        end else if (|req) begin
          // Direct handoff on the release edge, no idle bubble.
          w_do_grant = 1'b1;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = 4'b0000;
          w_gnt_id_nxt    = 2'b00;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_do_grant) begin
      w_state_nxt     = ST_GRANT;
      w_gnt_nxt       = onehot4(w_win);
      w_gnt_id_nxt    = w_win;
      w_gnt_valid_nxt = 1'b1;
      w_ptr_nxt       = w_win;
`ifdef HOLD_TIMEOUT_EN
      w_hold_cnt_nxt  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'b00;
      r_gnt_valid <= 1'b0;
      r_ptr       <= 2'b11;
`ifdef HOLD_TIMEOUT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_ptr       <= w_ptr_nxt;
`ifdef HOLD_TIMEOUT_EN
      r_hold_cnt  <= w_hold_cnt_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4req
//
// Self-checking bench for rr_arbiter_4req. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter_4req;

`ifdef HOLD_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 8;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int n_checks;
  int n_fail;

  rr_arbiter_4req #(
    .MAX_HOLD(TB_MAX_HOLD),
    .CNT_W   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [3:0] eg,
                       input logic [1:0] ei, input logic ev);
    n_checks++;
    if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b, expected gnt=%b id=%0d valid=%b",
               nm, gnt, gnt_id, gnt_valid, eg, ei, ev);
    end
  endtask

  // Drive req on the falling edge, let one rising edge pass, then settle.
  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    req      = 4'b0000;

    // {req applied, expected gnt, id, valid after the following edge}
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0}; // idle stays idle
    vecs[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1}; // first grant
    vecs[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1}; // hold
    vecs[3]  = '{4'b0011, 4'b0001, 2'd0, 1'b1}; // non-owner ignored
    vecs[4]  = '{4'b0010, 4'b0010, 2'd1, 1'b1}; // handoff to 1
    vecs[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0}; // release to idle, ptr=1
    vecs[6]  = '{4'b1111, 4'b0100, 2'd2, 1'b1}; // search from 2
    vecs[7]  = '{4'b1011, 4'b1000, 2'd3, 1'b1}; // owner 2 drops -> 3
    vecs[8]  = '{4'b0111, 4'b0001, 2'd0, 1'b1}; // wrap to 0
    vecs[9]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
    vecs[10] = '{4'b1101, 4'b0100, 2'd2, 1'b1};
    vecs[11] = '{4'b1011, 4'b1000, 2'd3, 1'b1};
    vecs[12] = '{4'b0111, 4'b0001, 2'd0, 1'b1}; // round-robin 0,1,2,3,0
    vecs[13] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[14] = '{4'b1000, 4'b1000, 2'd3, 1'b1}; // skips empty slots 1,2
    vecs[15] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    // Reset with no requests, outputs quiet before and after release.
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_init", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(4'b0000);
      check($sformatf("post_reset_idle%0d", i), 4'b0000, 2'd0, 1'b0);
    end

    // Main vector table.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].vld);
    end

    // Long hold with a competing requester.
    do_reset();
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      step(4'b0011);
      check($sformatf("timeout_alt%0d", i),
            ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010,
            ((i / 4) % 2 == 0) ? 2'd0 : 2'd1, 1'b1);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0001);
      check($sformatf("timeout_regrant%0d", i), 4'b0001, 2'd0, 1'b1);
    end
`else
    for (int i = 0; i < 12; i++) begin
      step(4'b0011);
      check($sformatf("hold_forever%0d", i), 4'b0001, 2'd0, 1'b1);
    end
`endif

    // Owner 3, reset mid-cycle clears without a clock edge.
    do_reset();
    step(4'b1000);
    check("owner3", 4'b1000, 2'd3, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_clear_owner3", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110);
    check("ptr_reset_a", 4'b0010, 2'd1, 1'b1);

    // Owner 1 before reset: a stale ptr=1 would pick 2, reset ptr picks 1.
    step(4'b0000);
    check("idle_before_b", 4'b0000, 2'd0, 1'b0);
    step(4'b0010);
    check("owner1", 4'b0010, 2'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_clear_owner1", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110);
    check("ptr_reset_b", 4'b0010, 2'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
